// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared single-port memory
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RESN,
  input  logic        IREQ,
  input  logic [31:0] IADDR,
  output logic [31:0] IRDATA,
  output logic        IACK,
  output logic        IERR,
  input  logic        DRD,
  input  logic        DWR,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic [2:0]  DLEN,
  output logic [31:0] DRDATA,
  output logic        DACK,
  output logic        DERR,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [3:0]  M_BE,
  output logic [31:0] M_WDATA,
  input  logic [31:0] M_RDATA,
  input  logic        M_READY,
  output logic        STALL
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [9:0] TO_LIM     = 10'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [9:0]  to_cnt;
  logic        served_fetch;
  logic [1:0]  d_off;
  logic [2:0]  d_len;

  logic        data_pend;
  logic        rule_fetch;
  logic        rule_data;
  logic        may_grant;
  logic        in_done;
  logic        grant_fetch;
  logic        grant_data;
  logic        len_byte;
  logic        len_half;
  logic        len_word;
  logic        data_legal;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic [31:0] rd_shift;
  logic [31:0] rd_data;

  // Fetch address bits [1:0] carry no meaning for a word fetch.
  logic unused_iaddr_lsb;
  assign unused_iaddr_lsb = ^IADDR[1:0];

  // Grant decision; in DONE the just-served requester still shows its stale
  // request, so if the priority rule picks it the arbiter falls back to IDLE.
  always_comb begin
    data_pend   = DRD | DWR;
    rule_fetch  = IREQ & (~data_pend | (starve_cnt == STARVE_LIM));
    rule_data   = data_pend & ~rule_fetch;
    in_done     = (state == DONE);
    may_grant   = (state == IDLE) | in_done;
    grant_fetch = may_grant & rule_fetch & ~(in_done & served_fetch);
    grant_data  = may_grant & rule_data & ~(in_done & ~served_fetch);
  end

  // Data request decode: legality, byte enables and write lane shift.
  always_comb begin
    len_byte   = (DLEN == 3'b001);
    len_half   = (DLEN == 3'b010);
    len_word   = (DLEN == 3'b100);
    data_legal = ~(DRD & DWR) & (len_byte | len_half | len_word)
               & ~(len_half & DADDR[0]) & ~(len_word & (|DADDR[1:0]));
    d_be = 4'b0000;
    case (DLEN)
      3'b001:  d_be = 4'b0001 << DADDR[1:0];
      3'b010:  d_be = 4'b0011 << {DADDR[1], 1'b0};
      3'b100:  d_be = 4'b1111;
      default: d_be = 4'b0000;
    endcase
    d_wdata = DATAO << {DADDR[1:0], 3'b000};
  end

  // Read return: move the addressed lane down and zero the unused upper bytes.
  always_comb begin
    rd_shift = M_RDATA >> {d_off, 3'b000};
    rd_data  = rd_shift;
    case (d_len)
      3'b001:  rd_data = {24'h0, rd_shift[7:0]};
      3'b010:  rd_data = {16'h0, rd_shift[15:0]};
      default: rd_data = rd_shift;
    endcase
  end

  assign STALL = (IREQ & ~IACK) | ((DRD | DWR) & ~DACK);

  // Arbiter FSM with all memory-side and requester-side outputs registered.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state        <= IDLE;
      starve_cnt   <= 4'd0;
      to_cnt       <= 10'd0;
      served_fetch <= 1'b0;
      d_off        <= 2'b00;
      d_len        <= 3'b000;
      IRDATA       <= 32'h0;
      IACK         <= 1'b0;
      IERR         <= 1'b0;
      DRDATA       <= 32'h0;
      DACK         <= 1'b0;
      DERR         <= 1'b0;
      M_REQ        <= 1'b0;
      M_WE         <= 1'b0;
      M_ADDR       <= 32'h0;
      M_BE         <= 4'b0000;
      M_WDATA      <= 32'h0;
    end else begin
      IACK <= 1'b0;
      IERR <= 1'b0;
      DACK <= 1'b0;
      DERR <= 1'b0;

      if (!IREQ || grant_fetch) begin
        starve_cnt <= 4'd0;
      end else if (grant_data) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      case (state)
        IDLE, DONE: begin
          M_REQ <= 1'b0;
          if (grant_fetch) begin
            state        <= BUSY;
            served_fetch <= 1'b1;
            to_cnt       <= 10'd0;
            M_REQ        <= 1'b1;
            M_WE         <= 1'b0;
            M_BE         <= 4'b1111;
            M_ADDR       <= {IADDR[31:2], 2'b00};
          end else if (grant_data) begin
            served_fetch <= 1'b0;
            d_off        <= DADDR[1:0];
            d_len        <= DLEN;
            if (data_legal) begin
              state   <= BUSY;
              to_cnt  <= 10'd0;
              M_REQ   <= 1'b1;
              M_WE    <= DWR;
              M_BE    <= d_be;
              M_ADDR  <= {DADDR[31:2], 2'b00};
              M_WDATA <= d_wdata;
            end else begin
              state  <= DONE;
              DACK   <= 1'b1;
              DERR   <= 1'b1;
              DRDATA <= 32'h0;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (M_READY || (to_cnt == TO_LIM)) begin
            state <= DONE;
            M_REQ <= 1'b0;
            M_WE  <= 1'b0;
            M_BE  <= 4'b0000;
            if (served_fetch) begin
              IACK   <= 1'b1;
              IERR   <= ~M_READY;
              IRDATA <= M_READY ? M_RDATA : 32'h0;
            end else begin
              DACK   <= 1'b1;
              DERR   <= ~M_READY;
              DRDATA <= M_READY ? rd_data : 32'h0;
            end
          end else begin
            to_cnt <= to_cnt + 10'd1;
          end
        end
        default: begin
          state <= IDLE;
          M_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule
